riscv_test_monitor: RTL
=======================

// Module: riscv_test_monitor
// PURPOSE
//  Pass/fail monitor for the riscv-tests ISA suite (rv32ui-p-*), placed directly downstream of the core in the
//  simulation harness. Consumes the core's retire stream and the gp (x3) value, detects the terminating ecall,
//  decodes pass/fail and the failing test number, and flags timeouts/hangs, so benches end on `done`, not a tick count.
// PARAMETERS
//  MAX_CYCLES    5000  cycles in RUN before TIMEOUT is declared
//  STALL_CYCLES  64    consecutive cycles without a retire before STALL (only with RISCV_TEST_MON_STALL_EN)
//  ECALL_INST    32'h0000_0073  instruction word treated as test termination
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  commit_valid  in   1   one instruction retired this cycle
//  commit_pc     in   32  PC of the retired instruction
//  commit_inst   in   32  instruction word of the retired instruction
//  gp_value      in   32  current x3 value, sampled with commit_valid
//  done          out  1   sticky: monitor reached a terminal state
//  pass          out  1   sticky: terminated with gp==1
//  fail          out  1   sticky: terminated with gp odd and !=1
//  fail_testnum  out  31  gp[31:1] captured at failing ecall, else 0
//  timeout       out  1   sticky: MAX_CYCLES elapsed without termination
//  stalled       out  1   sticky: retire stream idle STALL_CYCLES cycles (0 when feature compiled out)
//  cycle_count   out  32  cycles spent in RUN
//  retire_count  out  32  instructions retired in RUN
//  end_pc        out  32  commit_pc of the terminating ecall, else 0
// BEHAVIOUR
//  - Reset: all outputs 0, state RUN, idle counter 0. rst mid-run discards all results and restarts in RUN.
//  - FSM: RUN -> PASS | FAIL | TIMEOUT | STALL; every terminal state is absorbing until rst.
//  - Terminating event: commit_valid && commit_inst==ECALL_INST && gp_value[0]==1.
//      gp_value==1 -> PASS; else FAIL with fail_testnum=gp_value[31:1]. end_pc <= commit_pc.
//  - ecall with gp_value[0]==0: ordinary retire (counted), no state change.
//  - All outputs registered; flags assert the cycle after the terminating retire (1-cycle latency).
//  - cycle_count: +1 every RUN cycle, including the terminating one; frozen in terminal states.
//  - retire_count: +1 per commit_valid in RUN, terminating ecall included; frozen afterwards.
//  - Both counters saturate at 32'hFFFF_FFFF, never wrap.
//  - TIMEOUT: in RUN when cycle_count==MAX_CYCLES-1 and no terminating event this cycle -> TIMEOUT next cycle.
//  - Priority on the same cycle: PASS/FAIL > TIMEOUT > STALL.
//  - Exactly one of pass/fail/timeout/stalled is 1 whenever done==1; all 0 while done==0.
//  - Inputs ignored once done; no X propagation from commit_pc/inst/gp_value when commit_valid==0.
// CONFIGURATION
//  RISCV_TEST_MON_STALL_EN defined: idle counter clears on commit_valid, else +1 in RUN; reaching STALL_CYCLES
//    -> STALL state, stalled=1, done=1 next cycle.
//  Not defined: no idle counter, STALL state unreachable, stalled tied 0; only PASS/FAIL/TIMEOUT terminate.
// TESTING
//  1 Pass: 10 plain retires, then ecall with gp=1 at pc=0x0000_05C0 -> next cycle done=1 pass=1 retire_count=11
//    end_pc=0x0000_05C0; outputs unchanged 100 cycles later.
//  2 Fail: ecall with gp=0x0000_0007 -> done=1 fail=1 fail_testnum=3 pass=0.
//  3 Ignored ecall: ecall with gp=0x0000_0002 -> done stays 0, retire_count +1; later ecall gp=1 -> pass.
//  4 Timeout: MAX_CYCLES=20, retires every cycle, no ecall -> done=timeout=1 after 20 RUN cycles,
//    cycle_count=20; ecall with gp=1 on cycle 20 instead -> pass=1, timeout=0.
//  5 Stall (STALL_EN, STALL_CYCLES=8): 3 retires then commit_valid=0 -> stalled=done=1 after 8 idle cycles;
//    compiled out -> stalled stays 0, timeout fires at MAX_CYCLES.
//  6 Reset mid-run and after FAIL: pulse rst one cycle -> all outputs 0 next cycle; fresh run passes normally.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: pass/fail monitor for the riscv-tests ISA suite.
// Watches the core's retire stream for the terminating ecall, decodes the
// gp (x3) convention into pass / fail(+test number), and flags runaway runs
// via a cycle-budget timeout.
//
// Optional build macro: RISCV_TEST_MON_STALL_EN
//   defined   -> an idle counter declares STALL after STALL_CYCLES cycles
//                without a retire.
//   undefined -> no idle counter, stalled is tied 0.
//
// All outputs are registered and sticky once done is set; only rst clears them.
module riscv_test_monitor #(
  parameter int unsigned MAX_CYCLES   = 5000,
  parameter int unsigned STALL_CYCLES = 64,
  parameter logic [31:0] ECALL_INST   = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic [31:0] gp_value,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [30:0] fail_testnum,
  output logic        timeout,
  output logic        stalled,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count,
  output logic [31:0] end_pc
);

  typedef enum logic [2:0] {
    StRun,
    StPass,
    StFail,
    StTimeout,
    StStall
  } state_e;

  // Timeout fires on the cycle whose pre-increment count is MAX_CYCLES-1,
  // so cycle_count reads exactly MAX_CYCLES once TIMEOUT is reached.
  localparam logic [31:0] CycleLimit = 32'(MAX_CYCLES - 1);

  state_e state_q;

  logic        term_evt;
  logic        gp_is_one;
  logic        timeout_hit;
  logic [31:0] cycle_inc;
  logic [31:0] retire_inc;

`ifdef RISCV_TEST_MON_STALL_EN
  localparam logic [31:0] StallLimit = 32'(STALL_CYCLES - 1);

  logic [31:0] idle_q;
  logic        stall_hit;
  logic [31:0] idle_inc;
`else
  // Stall detection compiled out: keep the parameter referenced and tie off.
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_CYCLES;
  assign stalled          = 1'b0;
`endif

  // Decode the terminating event and the saturating counter increments.
  always_comb begin
    // && short-circuits, so unqualified inst/gp contents never reach the FSM.
    term_evt    = commit_valid && (commit_inst == ECALL_INST) && gp_value[0];
    gp_is_one   = (gp_value == 32'd1);
    timeout_hit = (cycle_count == CycleLimit);
    cycle_inc   = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    retire_inc  = (retire_count == 32'hFFFF_FFFF) ? retire_count : retire_count + 32'd1;
`ifdef RISCV_TEST_MON_STALL_EN
    idle_inc    = (idle_q == 32'hFFFF_FFFF) ? idle_q : idle_q + 32'd1;
    stall_hit   = !commit_valid && (idle_q == StallLimit);
`endif
  end

  // Monitor FSM with registered, sticky result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      fail_testnum <= '0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
      end_pc       <= '0;
`ifdef RISCV_TEST_MON_STALL_EN
      stalled      <= 1'b0;
      idle_q       <= '0;
`endif
    end else begin
      case (state_q)
        StRun: begin
          cycle_count <= cycle_inc;
          if (commit_valid) begin
            retire_count <= retire_inc;
          end
`ifdef RISCV_TEST_MON_STALL_EN
          idle_q <= commit_valid ? 32'd0 : idle_inc;
`endif
          // Priority: PASS/FAIL > TIMEOUT > STALL.
          if (term_evt) begin
            done   <= 1'b1;
            end_pc <= commit_pc;
            if (gp_is_one) begin
              state_q <= StPass;
              pass    <= 1'b1;
            end else begin
              state_q      <= StFail;
              fail         <= 1'b1;
              fail_testnum <= gp_value[31:1];
            end
          end else if (timeout_hit) begin
            state_q <= StTimeout;
            done    <= 1'b1;
            timeout <= 1'b1;
`ifdef RISCV_TEST_MON_STALL_EN
          end else if (stall_hit) begin
            state_q <= StStall;
            done    <= 1'b1;
            stalled <= 1'b1;
`endif
          end
        end
        // Terminal states are absorbing; every output holds until rst.
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Exactly one result flag while done, none before.
  a_onehot_when_done : assert property (@(posedge clk) disable iff (rst)
    done |-> $onehot({pass, fail, timeout, stalled}));
  a_quiet_when_running : assert property (@(posedge clk) disable iff (rst)
    !done |-> ({pass, fail, timeout, stalled} == 4'b0000));
  a_testnum_only_on_fail : assert property (@(posedge clk) disable iff (rst)
    !fail |-> (fail_testnum == '0));

endmodule
